// File: rtl/pll_lock_supervisor_if.sv
// PLL control/status bundle between the lock supervisor (master) and the PLL/system side (slave).
// Combinational wiring only; the bundle has no flow control.
interface pll_lock_supervisor_if;
  logic       pll_lock;
  logic       pll_reset;
  logic       sys_reset;
  logic       locked;
  logic       fault;
  logic [7:0] retry_count;
  logic [7:0] lol_count;

  modport master (
    input  pll_lock,
    output pll_reset, sys_reset, locked, fault, retry_count, lol_count
  );

  modport slave (
    output pll_lock,
    input  pll_reset, sys_reset, locked, fault, retry_count, lol_count
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset and system-reset release from the reference clock, with timeout retries and loss-of-lock recovery.
// Outputs are decoded from registered state; lock reaches the FSM 2 cycles after pll_lock; there is no backpressure.
module pll_lock_supervisor #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned SYS_RST_CYCLES      = 256,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic                          clkin,
  input  logic                          reset,
  pll_lock_supervisor_if.master         bus
);

  localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MAX_CD  = (LOCK_STABLE_CYCLES > SYS_RST_CYCLES) ? LOCK_STABLE_CYCLES : SYS_RST_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PLL_T  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_T   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAB_T = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SYSR_T = CNT_W'(SYS_RST_CYCLES - 1);
  localparam logic [7:0]       RETRY_MAX = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_SYS_RST,
    S_RUN,
    S_FAULT
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             lock_meta;
  logic             lock_s;
  logic [7:0]       retry_count;
  logic [7:0]       lol_count;
  logic             retry_inc;
  logic             lol_inc;

  always_ff @(posedge clkin) begin
    if (reset) begin
      state       <= S_PLL_RST;
      cnt         <= '0;
      lock_meta   <= 1'b0;
      lock_s      <= 1'b0;
      retry_count <= 8'd0;
      lol_count   <= 8'd0;
    end else begin
      // pll_lock is asynchronous to clkin
      lock_meta <= bus.pll_lock;
      lock_s    <= lock_meta;
      state     <= state_nx;
      if (state_nx != state) begin
        cnt <= '0;
      end else if (state != S_RUN && state != S_FAULT) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (retry_inc) begin
        retry_count <= retry_count + 8'd1;
      end
      if (lol_inc && lol_count != 8'hFF) begin
        lol_count <= lol_count + 8'd1;
      end
    end
  end

  // A lock drop takes priority over any terminal count in the same cycle.
  always_comb begin
    state_nx  = state;
    retry_inc = 1'b0;
    lol_inc   = 1'b0;
    case (state)
      S_PLL_RST: begin
        if (cnt == PLL_T) state_nx = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_nx = S_STABLE;
        end else if (cnt == TO_T) begin
          if (retry_count == RETRY_MAX) begin
            state_nx = S_FAULT;
          end else begin
            state_nx  = S_PLL_RST;
            retry_inc = 1'b1;
          end
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_nx = S_WAIT_LOCK;
        end else if (cnt == STAB_T) begin
          state_nx = S_SYS_RST;
        end
      end
      S_SYS_RST: begin
        if (!lock_s) begin
          state_nx = S_PLL_RST;
          lol_inc  = 1'b1;
        end else if (cnt == SYSR_T) begin
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_nx = S_PLL_RST;
          lol_inc  = 1'b1;
        end
      end
      S_FAULT: begin
        state_nx = S_FAULT;
      end
      default: begin
        state_nx = S_PLL_RST;
      end
    endcase
  end

  assign bus.pll_reset   = (state == S_PLL_RST) || (state == S_FAULT);
  assign bus.sys_reset   = (state != S_RUN);
  assign bus.locked      = (state == S_RUN);
  assign bus.fault       = (state == S_FAULT);
  assign bus.retry_count = retry_count;
  assign bus.lol_count   = lol_count;

endmodule
